// File: rtl/uart_defines.sv
// Shared constants, host FSM state type and frame helper
// for the host-side UART programming link.
package uart_defines;

  localparam logic [7:0] CMD_PROG  = 8'h50;
  localparam logic [7:0] CMD_START = 8'h53;
  localparam logic [7:0] RSP_ACK   = 8'h06;

  localparam logic [3:0] FRAME_LAST = 4'd8;

  typedef enum logic [2:0] {
    HS_IDLE,
    HS_FETCH,
    HS_LATCH,
    HS_SEND,
    HS_WAIT_ACK,
    HS_START,
    HS_WAIT_SACK,
    HS_RUN
  } host_state_t;

  // byte n of a program frame: command, then addr and data LSB first
  function automatic logic [7:0] prog_byte(
    input logic [3:0]  n,
    input logic [31:0] addr,
    input logic [31:0] data
  );
    logic [63:0] payload;
    logic [5:0]  sel;
    payload = {data, addr};
    sel     = {n[2:0] - 3'd1, 3'b000};
    return (n == 4'd0) ? CMD_PROG : payload[sel +: 8];
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running 16x oversample tick generator.
// One tick every DIV clocks.
module uart_baud_gen #(
  parameter int DIV = 54
) (
  input  logic clk,
  input  logic rstn,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_phy.sv
// 8N1 receiver, 16x oversampled, mid-bit sampling.
// Frames with a bad stop bit are dropped.
module uart_rx_phy (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tick,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_data
);

  logic [1:0] sync;
  logic       rxs;
  logic       busy;
  logic [3:0] tcnt;
  logic [3:0] bitn;
  logic [7:0] sh;

  assign rxs = sync[1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync     <= 2'b11;
      busy     <= 1'b0;
      tcnt     <= '0;
      bitn     <= '0;
      sh       <= '0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      sync     <= {sync[0], rx};
      rx_valid <= 1'b0;
      if (!busy) begin
        if (!rxs) begin
          busy <= 1'b1;
          tcnt <= '0;
          bitn <= '0;
        end
      end else if (tick) begin
        tcnt <= tcnt + 4'd1;
        if (bitn == 4'd0) begin
          // re-check the start bit at its centre to reject glitches
          if (tcnt == 4'd7) begin
            if (rxs) begin
              busy <= 1'b0;
            end else begin
              tcnt <= '0;
              bitn <= 4'd1;
            end
          end
        end else if (tcnt == 4'd15) begin
          if (bitn == 4'd9) begin
            busy     <= 1'b0;
            rx_valid <= rxs;
            if (rxs) begin
              rx_data <= sh;
            end
          end else begin
            sh   <= {rxs, sh[7:1]};
            bitn <= bitn + 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_phy.sv
// 8N1 transmitter, 16 ticks per bit.
// tx_ready is high only while no frame is in flight.
module uart_tx_phy (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tick,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx
);

  logic       busy;
  logic [9:0] sh;
  logic [3:0] tcnt;
  logic [3:0] bitn;

  assign tx_ready = !busy;
  assign tx       = busy ? sh[0] : 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy <= 1'b0;
      sh   <= '1;
      tcnt <= '0;
      bitn <= '0;
    end else if (!busy) begin
      if (tx_valid) begin
        busy <= 1'b1;
        sh   <= {1'b1, tx_data, 1'b0};
        tcnt <= '0;
        bitn <= '0;
      end
    end else if (tick) begin
      tcnt <= tcnt + 4'd1;
      if (tcnt == 4'd15) begin
        if (bitn == 4'd9) begin
          busy <= 1'b0;
        end else begin
          sh   <= {1'b1, sh[9:1]};
          bitn <= bitn + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_word_assembler.sv
// Packs received bytes into 32-bit words, first byte in bits 7:0.
// word holds the last complete word between pulses.
module uart_word_assembler (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  cnt;
  logic [23:0] sh;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt        <= '0;
      sh         <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        cnt <= '0;
      end else if (byte_valid) begin
        cnt <= cnt + 2'd1;
        sh  <= {byte_data, sh[23:8]};
        if (cnt == 2'd3) begin
          word       <= {byte_data, sh};
          word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_host_loader.sv
// Host end of the CPU UART link: streams a ROM image as acked
// program frames, sends start, then collects print words.
module uart_host_loader
  import uart_defines::*;
#(
  parameter int          IMG_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          ACK_TIMEOUT = 2_000_000,
  parameter int          BAUD_DIV    = 54,
  localparam int         IDX_W       = (IMG_WORDS > 1) ? $clog2(IMG_WORDS) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             go,
  output logic             img_rd,
  output logic [IDX_W-1:0] img_idx,
  input  logic [31:0]      img_data,
  output logic             tx,
  input  logic             rx,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             print_valid,
  output logic [31:0]      print_word
);

  localparam int TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

  logic       tick;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;

  host_state_t      state, state_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic [3:0]       bcnt, bcnt_d;
  logic [31:0]      data_q, data_d;
  logic [TW-1:0]    tmr;
  logic             err_d;
  logic             done_d;
  logic             asm_clr;
  logic             asm_byte;
  logic             ack;
  logic             bad;
  logic             expired;
  logic             waiting;
  logic [31:0]      addr;

  uart_baud_gen #(.DIV(BAUD_DIV)) u_baud (
    .clk  (clk),
    .rstn (rstn),
    .tick (tick)
  );

  uart_tx_phy u_tx (
    .clk      (clk),
    .rstn     (rstn),
    .tick     (tick),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .tx       (tx)
  );

  uart_rx_phy u_rx (
    .clk      (clk),
    .rstn     (rstn),
    .tick     (tick),
    .rx       (rx),
    .rx_valid (rx_valid),
    .rx_data  (rx_data)
  );

  uart_word_assembler u_asm (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (asm_clr),
    .byte_valid (asm_byte),
    .byte_data  (rx_data),
    .word       (print_word),
    .word_valid (print_valid)
  );

  assign addr     = BASE_ADDR + (32'(idx) << 2);
  assign ack      = rx_valid && (rx_data == RSP_ACK);
  assign bad      = rx_valid && !ack;
  assign expired  = (tmr == TW'(ACK_TIMEOUT - 1));
  assign asm_byte = rx_valid && (state == HS_RUN) && !go;
  assign img_idx  = idx;
  assign busy     = !(state == HS_IDLE || state == HS_RUN);

  // ack window opens once the last stop bit has left the line
  assign waiting  = (state == HS_WAIT_ACK || state == HS_WAIT_SACK)
                    && tx_ready;

  always_comb begin
    state_d  = state;
    idx_d    = idx;
    bcnt_d   = bcnt;
    data_d   = data_q;
    err_d    = error;
    done_d   = 1'b0;
    asm_clr  = 1'b0;
    img_rd   = 1'b0;
    tx_valid = 1'b0;
    tx_data  = CMD_PROG;
    unique case (state)
      HS_IDLE, HS_RUN: begin
        if (go) begin
          state_d = HS_FETCH;
          idx_d   = '0;
          err_d   = 1'b0;
          asm_clr = 1'b1;
        end
      end
      HS_FETCH: begin
        img_rd  = 1'b1;
        state_d = HS_LATCH;
      end
      HS_LATCH: begin
        data_d  = img_data;
        bcnt_d  = '0;
        state_d = HS_SEND;
      end
      HS_SEND: begin
        tx_valid = 1'b1;
        tx_data  = prog_byte(bcnt, addr, data_q);
        if (tx_ready) begin
          if (bcnt == FRAME_LAST) begin
            state_d = HS_WAIT_ACK;
          end else begin
            bcnt_d = bcnt + 4'd1;
          end
        end
      end
      HS_WAIT_ACK: begin
        if (ack) begin
          if (idx == IDX_W'(IMG_WORDS - 1)) begin
            state_d = HS_START;
          end else begin
            idx_d   = idx + IDX_W'(1);
            state_d = HS_FETCH;
          end
        end else if (bad || expired) begin
          err_d   = 1'b1;
          state_d = HS_IDLE;
        end
      end
      HS_START: begin
        tx_valid = 1'b1;
        tx_data  = CMD_START;
        if (tx_ready) begin
          state_d = HS_WAIT_SACK;
        end
      end
      HS_WAIT_SACK: begin
        if (ack) begin
          done_d  = 1'b1;
          state_d = HS_RUN;
        end else if (bad || expired) begin
          err_d   = 1'b1;
          state_d = HS_IDLE;
        end
      end
      default: state_d = HS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= HS_IDLE;
      idx    <= '0;
      bcnt   <= '0;
      data_q <= '0;
      error  <= 1'b0;
      done   <= 1'b0;
      tmr    <= '0;
    end else begin
      state  <= state_d;
      idx    <= idx_d;
      bcnt   <= bcnt_d;
      data_q <= data_d;
      error  <= err_d;
      done   <= done_d;
      if (!waiting) begin
        tmr <= '0;
      end else if (!expired) begin
        tmr <= tmr + TW'(1);
      end
    end
  end

endmodule
